// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin front end sharing one combinational ALU
// between two requesters; MUL is built from 32 shift-add steps.
module alu_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;

  state_t      r_state;
  logic        r_last;
  logic        r_id;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_rsp_valid;
  logic [31:0] r_result;

  logic        w_idle;
  logic        w_g0;
  logic        w_g1;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [3:0]  w_op;
  logic [31:0] w_acc_nxt;

  // Grant: r_last=1 means port 1 won last, so port 0 wins a tie.
  // rst_n gates grants so ready stays low while reset is held.
  always_comb begin
    w_idle = rst_n && (r_state == S_IDLE);
    w_g0   = w_idle && req0_valid && (!req1_valid || r_last);
    w_g1   = w_idle && req1_valid && (!req0_valid || !r_last);
    w_a    = w_g1 ? req1_a  : req0_a;
    w_b    = w_g1 ? req1_b  : req0_b;
    w_op   = w_g1 ? req1_op : req0_op;
  end

  // Shared ALU drive: captured operands in EXEC, acc+mcand in MUL.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    unique case (r_state)
      S_EXEC: begin
        alu_a    = r_a;
        alu_b    = r_b;
        alu_ctrl = r_op;
      end
      S_MUL: begin
        alu_a    = r_acc;
        alu_b    = r_a;
        alu_ctrl = OP_ADD;
      end
      default: ;
    endcase
  end

  // Accumulate only when the current multiplier bit is set.
  always_comb begin
    w_acc_nxt = r_b[0] ? alu_result : r_acc;
  end

  // Scheduler FSM; r_a/r_b double as mcand/mplier during MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_g0 || w_g1) begin
            r_last  <= w_g1;
            r_id    <= w_g1;
            r_a     <= w_a;
            r_b     <= w_b;
            r_op    <= w_op;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= (w_op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_result    <= alu_result;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_result    <= w_acc_nxt;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Zero flag comes from the held result, qualified by valid.
  always_comb begin
    req0_ready = w_g0;
    req1_ready = w_g1;
    rsp_valid  = r_rsp_valid;
    rsp_id     = r_id;
    rsp_result = r_result;
    rsp_zero   = r_rsp_valid && (r_result == '0);
    busy       = (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed checks of arbitration, latency,
// shift-add MUL, response back-pressure and mid-op reset.
module tb_alu_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl;
  logic        busy;

  int n_vec;
  int n_fail;

  alu_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; unlisted codes return a^b.
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0011: alu_result = alu_a * alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b1000: alu_result = alu_a << alu_b[4:0];
      4'b1001: alu_result = alu_a >> alu_b[4:0];
      4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1011: alu_result = {31'd0, alu_a == alu_b};
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'b0010;
    req1_a = 32'd3; req1_b = 32'd4; req1_op = 4'b0010;

    // reset with both requesters valid
    #2;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_ctrl", alu_ctrl, 4'd0);
    chk("rst_zero", rsp_zero, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single ADD on port 0
    req0_valid = 1'b1;
    req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'b0010;
    #1;
    chk("add_ready0", req0_ready, 1'b1);
    chk("add_ready1", req1_ready, 1'b0);
    step();
    req0_a = 32'd100;
    #1;
    chk("add_busy", busy, 1'b1);
    chk("add_alu_a", alu_a, 32'd5);
    chk("add_alu_b", alu_b, 32'd7);
    chk("add_alu_ctrl", alu_ctrl, 4'b0010);
    chk("add_exec_noready", req0_ready, 1'b0);
    step();
    chk("add_rsp_valid", rsp_valid, 1'b1);
    chk("add_result", rsp_result, 32'd12);
    chk("add_zero", rsp_zero, 1'b0);
    chk("add_id", rsp_id, 1'b0);
    chk("add_resp_alu_ctrl", alu_ctrl, 4'd0);
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    step();
    chk("add_done_valid", rsp_valid, 1'b0);
    chk("add_done_busy", busy, 1'b0);
    rsp_ready = 1'b0;

    // fresh reset, then both ports valid every cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd9;  req0_b = 32'd9;  req0_op = 4'b0110;
    req1_valid = 1'b1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'b0001;
    rsp_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic e1;
      e1 = (k % 2) == 1;
      #1;
      chk("rr_ready0", req0_ready, !e1);
      chk("rr_ready1", req1_ready, e1);
      step();
      chk("rr_exec_noready", req0_ready | req1_ready, 1'b0);
      step();
      chk("rr_rsp_valid", rsp_valid, 1'b1);
      chk("rr_id", rsp_id, e1);
      chk("rr_result", rsp_result, e1 ? 32'hFF : 32'h0);
      chk("rr_zero", rsp_zero, !e1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;

    // MUL on port 1: 0x10000 * 0x10001, overflow dropped
    req1_valid = 1'b1;
    req1_a = 32'h10000; req1_b = 32'h10001; req1_op = 4'b0011;
    #1;
    chk("mul_ready1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    chk("mul_step0_alu_a", alu_a, 32'd0);
    chk("mul_step0_alu_b", alu_b, 32'h10000);
    for (int i = 0; i < 32; i++) begin
      chk("mul_alu_ctrl", alu_ctrl, 4'b0010);
      chk("mul_no_rsp", rsp_valid, 1'b0);
      step();
    end
    chk("mul_rsp_valid", rsp_valid, 1'b1);
    chk("mul_result", rsp_result, 32'h00010000);
    chk("mul_id", rsp_id, 1'b1);
    chk("mul_alu_idle", alu_ctrl, 4'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // back-pressure: rsp_ready low for 10 cycles
    req0_valid = 1'b1;
    req0_a = 32'hFF00FF00; req0_b = 32'h0F0F0F0F; req0_op = 4'b0000;
    #1;
    chk("bp_ready0", req0_ready, 1'b1);
    step();
    req0_a = 32'd3; req0_b = 32'd5; req0_op = 4'b1111;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_result", rsp_result, 32'h0F000F00);
      chk("bp_noready", req0_ready | req1_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_handoff_noready", req0_ready, 1'b0);
    step();
    rsp_ready = 1'b0;
    chk("bp_accept_next", req0_ready, 1'b1);
    chk("bp_idle_valid", rsp_valid, 1'b0);
    step();
    req0_valid = 1'b0;
    chk("unk_alu_ctrl", alu_ctrl, 4'b1111);
    step();
    chk("unk_result", rsp_result, 32'd6);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // reset in the middle of a MUL
    req0_valid = 1'b1;
    req0_a = 32'd7; req0_b = 32'd9; req0_op = 4'b0011;
    step();
    req0_valid = 1'b0;
    repeat (15) step();
    chk("mid_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0010;
    req1_valid = 1'b1; req1_op = 4'b0010;
    #1;
    chk("mr_rsp_valid", rsp_valid, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_alu_a", alu_a, 32'd0);
    chk("mr_alu_b", alu_b, 32'd0);
    chk("mr_alu_ctrl", alu_ctrl, 4'd0);
    chk("mr_ready", req0_ready | req1_ready, 1'b0);
    chk("mr_result", rsp_result, 32'd0);
    chk("mr_id", rsp_id, 1'b0);
    repeat (3) step();
    chk("mr_hold_valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("mr_first_ready0", req0_ready, 1'b1);
    chk("mr_first_ready1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk("mr_post_result", rsp_result, 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
